cam_align_ctrl: RTL
===================

# cam_align_ctrl

Automatic word-alignment sequencer for one camera's LVDS receiver. It runs in that camera's `rxc` domain. While the sensor transmits its training pattern, it checks each deserialized 8-bit lane in turn. It issues single-cycle bitslip pulses to the altlvdsrx `rx_data_align` inputs until every lane shows the pattern stably. It replaces the manual BAR-driven align-request path for that camera and reports per-lane result and slip counts for register readback.

## Interface
Parameters:
- `NLANES`, 5: lanes checked; lanes 0..3 are data, lane 4 is sync.
- `TRAIN`, 8'h3A: expected training byte on every lane.
- `SETTLE`, 16: idle cycles after each bitslip, and before the first check of each lane.
- `MATCH`, 64: consecutive matching cycles required to declare a lane aligned.
- `MAX_SLIPS`, 8: bitslips attempted per lane before it is declared failed; range 1..15.

Ports:
- `c`  in  1: camera rx clock; the only clock.
- `rst`  in  1: synchronous, active-high reset.
- `start`  in  1: one-cycle request to begin alignment; already synchronized and one-shotted by the caller.
- `rx_locked`  in  1: LVDS PLL lock, synchronized to `c`.
- `rxd`  in  8*NLANES: lane i is `rxd[8*i+7:8*i]`.
- `align`  out  NLANES: one-hot, one-cycle bitslip pulse per lane.
- `busy`  out  1: high in any state other than IDLE and DONE.
- `done`  out  1: sticky completion flag.
- `fail`  out  1: sticky; set if any lane exhausted MAX_SLIPS.
- `lane_ok`  out  NLANES: per-lane aligned flag.
- `slips`  out  4*NLANES: per-lane count of bitslips issued.

## Operation
- States: IDLE, WAIT_LOCK, SETTLE, CHECK, SLIP, NEXT, DONE. Internal state: `lane` index, `cnt` (shared settle/match counter), per-lane slip counters.
- **IDLE / DONE**
  - On `start`: clear `done`, `fail`, `lane_ok`, all `slips`; set lane=0; go to WAIT_LOCK.
  - Otherwise hold.
- **WAIT_LOCK**: when `rx_locked`=1, set cnt=0 and go to SETTLE.
- **SETTLE**
  - Count SETTLE cycles.
  - On cycle SETTLE: cnt=0, go to CHECK.
- **CHECK**, each cycle:
  - If lane byte == TRAIN: increment cnt. On the MATCH-th consecutive match, set `lane_ok[lane]` and go to NEXT.
  - On mismatch with slips[lane] < MAX_SLIPS: go to SLIP.
  - On mismatch with slips[lane] == MAX_SLIPS: set `fail` and go to NEXT; `lane_ok[lane]` stays 0.
- **SLIP** (one cycle):
  - `align[lane]`=1; slips[lane]++; cnt=0.
  - Go to SETTLE.
- **NEXT** (one cycle):
  - If lane == NLANES-1: go to DONE and set `done`.
  - Otherwise lane++, cnt=0, go to SETTLE.
- **Lock loss**: `rx_locked`=0 in SETTLE, CHECK, SLIP or NEXT takes priority over every other transition:
  - clear `lane_ok` and `slips`; lane=0.
  - go to WAIT_LOCK.
  - No `align` pulse is issued that cycle.
- `start` while busy is ignored.
- `slips` counters never exceed MAX_SLIPS; there is no wrap.
- A mismatch anywhere in CHECK restarts the match run, because the lane slips and re-enters SETTLE.

## Timing
- All outputs are registered.
- Reset values: state IDLE, `align`=0, `busy`=0, `done`=0, `fail`=0, `lane_ok`=0, `slips`=0.
- `start` sampled high in cycle 0 → WAIT_LOCK in cycle 1; `busy` high from cycle 1.
- With `rx_locked`=1, lane 0 SETTLE occupies cycles 2..SETTLE+1 and CHECK begins at cycle SETTLE+2.
- Clean lane (no slips): SETTLE+MATCH+1 cycles, including NEXT.
- Each slip adds 1+SETTLE cycles plus the CHECK cycles consumed before the mismatch.
- All lanes clean: `done`=1 and `busy`=0 from cycle 2+NLANES*(SETTLE+MATCH+1); 407 with defaults.
- `align` is high for exactly one cycle.
- Consecutive `align` pulses are at least SETTLE+2 cycles apart.
- At most one `align` bit is high in any cycle.
- Reset asserted mid-operation: all outputs return to reset values on the next edge; any in-flight `align` pulse is dropped.

## Test plan
- **Clean run**: defaults, `rx_locked`=1, all lanes constant 8'h3A, `start` at cycle 0 → `align` never pulses; `done` rises at cycle 407; `lane_ok`=5'h1F; `slips`=0; `fail`=0.
- **Bit-rotated lane**:
  - Stimulus: lane 2 shows TRAIN rotated by 3. The bench model rotates that lane by one bit per `align[2]` pulse, with 2-cycle latency.
  - Required: exactly 3 `align[2]` pulses, each ≥18 cycles apart; slips[2]=3; `lane_ok`=5'h1F; `fail`=0.
- **Unalignable lane**: sync lane stuck at 8'h00 → 8 pulses on `align[4]`; slips[4]=8; `lane_ok`=5'h0F; `fail`=1; `done`=1.
- **Lock loss**: drop `rx_locked` for 5 cycles during lane 1 CHECK → `lane_ok` cleared, no pulse that cycle; after relock, the sequence restarts at lane 0 and completes with `lane_ok`=5'h1F.
- **Start/reset edges**:
  - `start` pulsed while busy → ignored; completion timing unchanged.
  - `rst` asserted in the cycle after a SLIP → all outputs 0 next cycle.
  - `start` after DONE → `done` clears in the following cycle and the run repeats.
- **Glitch in match run**: one mismatching byte on lane 0 at CHECK cycle 40 → one `align[0]` pulse; slips[0]=1. With the bench model rotating back, the lane re-achieves 64 matches.

Source files
------------

// File: rtl/cam_align_ctrl.sv
// cam_align_ctrl: LVDS word-alignment sequencer for one camera.
// Walks the lanes in turn, bitslipping each until the training byte holds.
module cam_align_ctrl #(
  parameter int         NLANES    = 5,
  parameter logic [7:0] TRAIN     = 8'h3A,
  parameter int         SETTLE    = 16,
  parameter int         MATCH     = 64,
  parameter int         MAX_SLIPS = 8
) (
  input  logic                c,
  input  logic                rst,
  input  logic                start,
  input  logic                rx_locked,
  input  logic [8*NLANES-1:0] rxd,
  output logic [NLANES-1:0]   align,
  output logic                busy,
  output logic                done,
  output logic                fail,
  output logic [NLANES-1:0]   lane_ok,
  output logic [4*NLANES-1:0] slips
);

  localparam int CMAX = (SETTLE > MATCH) ? SETTLE : MATCH;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int LW   = (NLANES > 1) ? $clog2(NLANES) : 1;

  localparam logic [CW-1:0] SET_LAST   = CW'(SETTLE - 1);
  localparam logic [CW-1:0] MATCH_LAST = CW'(MATCH - 1);
  localparam logic [LW-1:0] LAST_LANE  = LW'(NLANES - 1);
  localparam logic [3:0]    SLIP_MAX   = 4'(MAX_SLIPS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_LOCK,
    S_SETTLE,
    S_CHECK,
    S_SLIP,
    S_NEXT,
    S_DONE
  } state_t;

  state_t state;
  state_t state_n;

  logic [LW-1:0]       lane;
  logic [LW-1:0]       lane_n;
  logic [CW-1:0]       cnt;
  logic [CW-1:0]       cnt_n;
  logic [NLANES-1:0]   lane_hot;
  logic [7:0]          lane_byte;
  logic [3:0]          slip_cur;
  logic [4*NLANES-1:0] slips_inc;
  logic                lock_lost;

  logic [NLANES-1:0]   align_n;
  logic                busy_n;
  logic                done_n;
  logic                fail_n;
  logic [NLANES-1:0]   lane_ok_n;
  logic [4*NLANES-1:0] slips_n;

  assign lane_hot = NLANES'(1) << lane;

  // Any lock drop while actively aligning restarts the whole sequence.
  assign lock_lost = !rx_locked &&
                     ((state == S_SETTLE) ||
                      (state == S_CHECK)  ||
                      (state == S_SLIP)   ||
                      (state == S_NEXT));

  // Mux out the current lane's byte and its slip count.
  always_comb begin
    lane_byte = '0;
    slip_cur  = '0;
    for (int i = 0; i < NLANES; i++) begin
      if (lane == LW'(i)) begin
        lane_byte = rxd[8*i +: 8];
        slip_cur  = slips[4*i +: 4];
      end
    end
  end

  // Slip counters with the current lane bumped by one.
  always_comb begin
    slips_inc = slips;
    for (int i = 0; i < NLANES; i++) begin
      if (lane_hot[i]) begin
        slips_inc[4*i +: 4] = slips[4*i +: 4] + 4'd1;
      end
    end
  end

  // Next-state and next-output logic; lock loss overrides everything.
  always_comb begin
    state_n   = state;
    lane_n    = lane;
    cnt_n     = cnt;
    align_n   = '0;
    done_n    = done;
    fail_n    = fail;
    lane_ok_n = lane_ok;
    slips_n   = slips;
    unique case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          done_n    = 1'b0;
          fail_n    = 1'b0;
          lane_ok_n = '0;
          slips_n   = '0;
          lane_n    = '0;
          cnt_n     = '0;
          state_n   = S_WAIT_LOCK;
        end
      end
      S_WAIT_LOCK: begin
        if (rx_locked) begin
          cnt_n   = '0;
          state_n = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (cnt == SET_LAST) begin
          cnt_n   = '0;
          state_n = S_CHECK;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      S_CHECK: begin
        if (lane_byte == TRAIN) begin
          if (cnt == MATCH_LAST) begin
            lane_ok_n = lane_ok | lane_hot;
            cnt_n     = '0;
            state_n   = S_NEXT;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end else if (slip_cur < SLIP_MAX) begin
          state_n = S_SLIP;
        end else begin
          fail_n  = 1'b1;
          cnt_n   = '0;
          state_n = S_NEXT;
        end
      end
      S_SLIP: begin
        align_n = lane_hot;
        slips_n = slips_inc;
        cnt_n   = '0;
        state_n = S_SETTLE;
      end
      S_NEXT: begin
        if (lane == LAST_LANE) begin
          done_n  = 1'b1;
          state_n = S_DONE;
        end else begin
          lane_n  = lane + 1'b1;
          cnt_n   = '0;
          state_n = S_SETTLE;
        end
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
    if (lock_lost) begin
      state_n   = S_WAIT_LOCK;
      lane_n    = '0;
      cnt_n     = '0;
      align_n   = '0;
      done_n    = done;
      fail_n    = fail;
      lane_ok_n = '0;
      slips_n   = '0;
    end
  end

  assign busy_n = !((state_n == S_IDLE) || (state_n == S_DONE));

  // State register.
  always_ff @(posedge c) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Datapath and registered outputs.
  always_ff @(posedge c) begin
    if (rst) begin
      lane    <= '0;
      cnt     <= '0;
      align   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      fail    <= 1'b0;
      lane_ok <= '0;
      slips   <= '0;
    end else begin
      lane    <= lane_n;
      cnt     <= cnt_n;
      align   <= align_n;
      busy    <= busy_n;
      done    <= done_n;
      fail    <= fail_n;
      lane_ok <= lane_ok_n;
      slips   <= slips_n;
    end
  end

endmodule
